// File: rtl/muldiv_unit_pkg.sv
// Shared execute-stage definitions: operation codes, multiply/divide FSM states
// and the {hi, lo} word type.
package cpu_defs;

    localparam int XLEN = 32;

    typedef logic [2*XLEN-1:0] hilo_t;

    // 4-bit encoding leaves spare codes; the unit ignores anything it does not own.
    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_MADD  = 4'd2,
        OP_MADDU = 4'd3,
        OP_MSUB  = 4'd4,
        OP_MSUBU = 4'd5,
        OP_DIV   = 4'd6,
        OP_DIVU  = 4'd7
    } oper_t;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} muldiv_state_t;

    function automatic logic is_mul_op(input oper_t op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_div_op(input oper_t op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_signed_op(input oper_t op);
        return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response handshake bundle between issue logic (master) and the
// multiply/divide unit (slave).
interface muldiv_unit_if
    import cpu_defs::*;
#(
    parameter int WIDTH = XLEN
) ();
    logic                 flush;
    logic                 req_valid;
    logic                 req_ready;
    oper_t                req_op;
    logic [WIDTH-1:0]     req_a;
    logic [WIDTH-1:0]     req_b;
    logic [2*WIDTH-1:0]   req_hilo;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [WIDTH-1:0]     resp_hi;
    logic [WIDTH-1:0]     resp_lo;
    logic                 busy;

    modport master (
        output flush, req_valid, req_op, req_a, req_b, req_hilo, resp_ready,
        input  req_ready, resp_valid, resp_hi, resp_lo, busy
    );

    modport slave (
        input  flush, req_valid, req_op, req_a, req_b, req_hilo, resp_ready,
        output req_ready, resp_valid, resp_hi, resp_lo, busy
    );
endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider on operand magnitudes with sign fixup on the way out.
// MULDIV_DIV_EARLY_OUT_EN: finish after one DIV cycle when b==0 or |a|<|b|.
module div_iter
    import cpu_defs::*;
#(
    parameter int WIDTH = XLEN,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);
    localparam int ITER = WIDTH / BPC;
    localparam int CW   = $clog2(ITER + 1);

    logic             active, neg_q, neg_r, dz, eo, early_hit;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pr, pq, dv, a_q, r_nx, q_nx;
    logic [WIDTH:0]   sh, diff;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s & x[WIDTH-1]) ? -x : x;
    endfunction

    // BPC restoring steps per cycle; the partial remainder is always < dv,
    // so a failed trial subtraction fits back into WIDTH bits.
    always_comb begin
        r_nx = pr;
        q_nx = pq;
        sh   = '0;
        diff = '0;
        for (int i = 0; i < BPC; i++) begin
            sh   = {r_nx, q_nx[WIDTH-1]};
            diff = sh - {1'b0, dv};
            q_nx = {q_nx[WIDTH-2:0], ~diff[WIDTH]};
            r_nx = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

`ifdef MULDIV_DIV_EARLY_OUT_EN
    assign early_hit = (cnt == CW'(ITER)) & (dz | (pq < dv));
`else
    assign early_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
            pr     <= '0;
            pq     <= '0;
            dv     <= '0;
            a_q    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            eo     <= 1'b0;
        end else if (flush) begin
            active <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= CW'(ITER);
            pr     <= '0;
            pq     <= mag(a, sgn);
            dv     <= mag(b, sgn);
            a_q    <= a;
            neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sgn & a[WIDTH-1];
            dz     <= (b == '0);
            eo     <= 1'b0;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else if (early_hit) begin
                cnt <= '0;
                eo  <= 1'b1;
            end else begin
                pr  <= r_nx;
                pq  <= q_nx;
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign done = active & (cnt == '0);

    // Divide-by-zero and early-out bypass the iterated result; both leave a in hi.
    always_comb begin
        if (dz) begin
            quo = '1;
            rem = a_q;
        end else if (eo) begin
            quo = '0;
            rem = a_q;
        end else begin
            quo = neg_q ? -pq : pq;
            rem = neg_r ? -pr : pr;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MADD/MSUB/DIV execution unit with valid/ready handshake and flush.
// Optional divide early-out via MULDIV_DIV_EARLY_OUT_EN (handled in div_iter).
module muldiv_unit
    import cpu_defs::*;
#(
    parameter int WIDTH              = XLEN,
    parameter int MUL_LAT            = 3,   // 1..4
    parameter int DIV_BITS_PER_CYCLE = 1    // 1 or 2, divides WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int W2     = 2 * WIDTH;
    localparam int STAGES = MUL_LAT - 1;

    muldiv_state_t    state_q, state_d;
    logic             accept, mul_start, div_start, div_done, req_sgn, m_add, m_sub;
    logic [WIDTH-1:0] div_quo, div_rem, hi_q, lo_q;
    logic [W2-1:0]    ma_x, mb_x, m_acc, prod, mul_res, mul_out;
    logic [STAGES:0]  vld_pipe;

    assign accept    = bus.req_valid & bus.req_ready & ~bus.flush;
    assign mul_start = accept & is_mul_op(bus.req_op);
    assign div_start = accept & is_div_op(bus.req_op);
    assign req_sgn   = is_signed_op(bus.req_op);

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_hi    = hi_q;
    assign bus.resp_lo    = lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ma_x  <= '0;
            mb_x  <= '0;
            m_acc <= '0;
            m_add <= 1'b0;
            m_sub <= 1'b0;
        end else if (mul_start) begin
            ma_x  <= {{WIDTH{req_sgn & bus.req_a[WIDTH-1]}}, bus.req_a};
            mb_x  <= {{WIDTH{req_sgn & bus.req_b[WIDTH-1]}}, bus.req_b};
            m_acc <= bus.req_hilo;
            m_add <= bus.req_op inside {OP_MADD, OP_MADDU};
            m_sub <= bus.req_op inside {OP_MSUB, OP_MSUBU};
        end
    end

    // Extended operands make the truncated 2W product correct for both signednesses.
    assign prod    = ma_x * mb_x;
    assign mul_res = m_add ? m_acc + prod : (m_sub ? m_acc - prod : prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else if (bus.flush) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= mul_start;
            for (int k = 1; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    generate
        if (STAGES == 0) begin : g_nopipe
            assign mul_out = mul_res;
        end else begin : g_pipe
            logic [STAGES:1][W2-1:0] dpipe;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dpipe <= '0;
                end else begin
                    dpipe[1] <= mul_res;
                    for (int k = 2; k <= STAGES; k++) dpipe[k] <= dpipe[k-1];
                end
            end
            assign mul_out = dpipe[STAGES];
        end
    endgenerate

    div_iter #(.WIDTH(WIDTH), .BPC(DIV_BITS_PER_CYCLE)) u_div (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.flush),
        .start (div_start),
        .sgn   (req_sgn),
        .a     (bus.req_a),
        .b     (bus.req_b),
        .done  (div_done),
        .quo   (div_quo),
        .rem   (div_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (mul_start) state_d = MUL;
                  else if (div_start) state_d = DIV;
            MUL:  if (vld_pipe[STAGES]) state_d = DONE;
            DIV:  if (div_done) state_d = DONE;
            DONE: if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flush beats everything, including a same-cycle consume in DONE.
        if (bus.flush) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == MUL && state_d == DONE) begin
            {hi_q, lo_q} <= mul_out;
        end else if (state_q == DIV && state_d == DONE) begin
            hi_q <= div_rem;
            lo_q <= div_quo;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: multiply/accumulate, divide, handshake, flush, reset.
module tb_muldiv_unit;
    import cpu_defs::*;

`ifdef MULDIV_DIV_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 33;
`endif

    typedef struct {
        oper_t       op;
        logic [31:0] a;
        logic [31:0] b;
        hilo_t       hilo;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32), .MUL_LAT(3), .DIV_BITS_PER_CYCLE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic issue(input oper_t op, input logic [31:0] a, input logic [31:0] b, input hilo_t hilo);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_hilo  = hilo;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // Edges after the accept edge until resp_valid is seen (bounded at 100).
    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!bus.resp_valid && lat < 100);
    endtask

    task automatic consume();
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    task automatic run_vectors(input string tag, input vec_t v[]);
        int lat;
        foreach (v[i]) begin
            issue(v[i].op, v[i].a, v[i].b, v[i].hilo);
            wait_resp(lat);
            n_cmp += 3;
            if (lat !== v[i].lat) begin
                n_fail++; $display("FAIL %s[%0d] latency: got %0d expected %0d", tag, i, lat, v[i].lat);
            end
            if (bus.resp_hi !== v[i].hi) begin
                n_fail++; $display("FAIL %s[%0d] hi: got %h expected %h", tag, i, bus.resp_hi, v[i].hi);
            end
            if (bus.resp_lo !== v[i].lo) begin
                n_fail++; $display("FAIL %s[%0d] lo: got %h expected %h", tag, i, bus.resp_lo, v[i].lo);
            end
            consume();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 2;
        if ({bus.req_ready, bus.resp_valid, bus.busy} !== 3'b100) begin
            n_fail++; $display("FAIL reset flags: got %b expected 100", {bus.req_ready, bus.resp_valid, bus.busy});
        end
        if ({bus.resp_hi, bus.resp_lo} !== 64'h0) begin
            n_fail++; $display("FAIL reset resp: got %h expected 0", {bus.resp_hi, bus.resp_lo});
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_mul();
        vec_t v[];
        v = new[6];
        v[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3, 64'h0,                   32'hFFFFFFFF, 32'hFFFFFFFA, 3};
        v[1] = '{OP_MULTU, 32'hFFFFFFFE, 32'd3, 64'h0,                   32'h00000002, 32'hFFFFFFFA, 3};
        v[2] = '{OP_MADD,  32'hFFFFFFFE, 32'd4, 64'h00000000_00000010,   32'h0,        32'h8,        3};
        v[3] = '{OP_MSUBU, 32'd1,        32'd1, 64'h0,                   32'hFFFFFFFF, 32'hFFFFFFFF, 3};
        v[4] = '{OP_MSUB,  32'd2,        32'd3, 64'h00000001_00000000,   32'h0,        32'hFFFFFFFA, 3};
        v[5] = '{OP_MADDU, 32'd1,        32'd1, 64'hFFFFFFFF_FFFFFFFF,   32'h0,        32'h0,        3};
        run_vectors("mul", v);
    endtask

    task automatic test_div();
        vec_t v[];
        v = new[9];
        v[0] = '{OP_DIV,  32'hFFFFFFF9, 32'd2,        64'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        v[1] = '{OP_DIVU, 32'd7,        32'd2,        64'h0, 32'd1,        32'd3,        33};
        v[2] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 64'h0, 32'h0,        32'h80000000, 33};
        v[3] = '{OP_DIVU, 32'h00001234, 32'd0,        64'h0, 32'h00001234, 32'hFFFFFFFF, EO_LAT};
        v[4] = '{OP_DIV,  32'hFFFFFF00, 32'd0,        64'h0, 32'hFFFFFF00, 32'hFFFFFFFF, EO_LAT};
        v[5] = '{OP_DIVU, 32'd3,        32'd5,        64'h0, 32'd3,        32'd0,        EO_LAT};
        v[6] = '{OP_DIV,  32'd7,        32'hFFFFFFFE, 64'h0, 32'd1,        32'hFFFFFFFD, 33};
        v[7] = '{OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 64'h0, 32'hFFFFFFFF, 32'd3,        33};
        v[8] = '{OP_DIV,  32'hFFFFFFFD, 32'd5,        64'h0, 32'hFFFFFFFD, 32'd0,        EO_LAT};
        run_vectors("div", v);
    endtask

    task automatic test_handshake();
        int lat;
        issue(OP_MULTU, 32'hFFFFFFFE, 32'd3, 64'h0);
        wait_resp(lat);
        for (int c = 0; c < 5; c++) begin
            n_cmp += 2;
            if ({bus.resp_valid, bus.req_ready} !== 2'b10) begin
                n_fail++; $display("FAIL hold[%0d] valid/ready: got %b expected 10", c, {bus.resp_valid, bus.req_ready});
            end
            if ({bus.resp_hi, bus.resp_lo} !== 64'h00000002_FFFFFFFA) begin
                n_fail++; $display("FAIL hold[%0d] data: got %h expected 00000002fffffffa", c, {bus.resp_hi, bus.resp_lo});
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++; $display("FAIL consume-cycle req_ready: got %b expected 0", bus.req_ready);
        end
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        n_cmp++;
        if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL after-consume ready/valid: got %b expected 10", {bus.req_ready, bus.resp_valid});
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        int lat;
        issue(OP_DIV, 32'd100, 32'd7, 64'h0);
        repeat (9) @(posedge clk);
        @(negedge clk) bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL flush-div busy/ready: got %b expected 01", {bus.busy, bus.req_ready});
        end
        repeat (40) begin
            @(posedge clk);
            #1 if (bus.resp_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL flush-div resp_valid cycles: got %0d expected 0", seen);
        end
        // flush alongside a request in IDLE: not accepted
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = OP_MULT; bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0; bus.flush = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL flush-idle busy: got %b expected 0", bus.busy);
        end
        // flush alongside resp_ready in DONE: flush wins, response dropped
        issue(OP_MULT, 32'd2, 32'd3, 64'h0);
        wait_resp(lat);
        @(negedge clk);
        bus.flush = 1'b1; bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0; bus.resp_ready = 1'b0;
        n_cmp++;
        if ({bus.resp_valid, bus.busy, bus.req_ready} !== 3'b001) begin
            n_fail++; $display("FAIL flush-done flags: got %b expected 001", {bus.resp_valid, bus.busy, bus.req_ready});
        end
    endtask

    task automatic test_ignored_op();
        issue(oper_t'(4'd9), 32'd5, 32'd6, 64'h0);
        n_cmp++;
        if ({bus.busy, bus.req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL ignored-op busy/ready: got %b expected 01", {bus.busy, bus.req_ready});
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(OP_MULTU, 32'd6, 32'd7, 64'h0);
        wait_resp(lat);
        consume();
        issue(OP_MULTU, 32'h00010000, 32'h00010000, 64'h0);
        wait_resp(lat);
        n_cmp += 2;
        if (lat !== 3) begin
            n_fail++; $display("FAIL b2b latency: got %0d expected 3", lat);
        end
        if ({bus.resp_hi, bus.resp_lo} !== 64'h00000001_00000000) begin
            n_fail++; $display("FAIL b2b data: got %h expected 0000000100000000", {bus.resp_hi, bus.resp_lo});
        end
        consume();
    endtask

    task automatic test_rst_mid_mul();
        issue(OP_MULT, 32'd5, 32'd7, 64'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp += 2;
        if ({bus.req_ready, bus.resp_valid, bus.busy} !== 3'b100) begin
            n_fail++; $display("FAIL rst-mid flags: got %b expected 100", {bus.req_ready, bus.resp_valid, bus.busy});
        end
        if ({bus.resp_hi, bus.resp_lo} !== 64'h0) begin
            n_fail++; $display("FAIL rst-mid resp: got %h expected 0", {bus.resp_hi, bus.resp_lo});
        end
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_op = OP_MULT;
        bus.req_a = '0; bus.req_b = '0; bus.req_hilo = '0; bus.resp_ready = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_handshake();
        test_flush();
        test_ignored_op();
        test_back_to_back();
        test_rst_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle multiply/divide execution unit; the sequential companion to the single-cycle integer ALU in the execute stage.
- Handles MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU and produces a 2*WIDTH {hi, lo} result.
- Uses a valid/ready request/response handshake with flush, so the issue logic can stall on it and squash it.

Parameters:
- WIDTH, 32, operand width in bits; hi and lo are WIDTH each.
- MUL_LAT, 3, multiply latency in cycles from accept to resp_valid; legal range 1..4.
- DIV_BITS_PER_CYCLE, 1, quotient bits retired per divide iteration; legal values 1 or 2, and must divide WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  squash the in-flight operation and any held response.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_op  in  oper_t  one of OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU.
- req_a  in  WIDTH  rs operand (dividend / multiplicand).
- req_b  in  WIDTH  rt operand (divisor / multiplier).
- req_hilo  in  2*WIDTH  current {hi, lo}, the accumulator for MADD/MSUB.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_hi  out  WIDTH  hi result (remainder for divide).
- resp_lo  out  WIDTH  lo result (quotient for divide).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; req_ready=1; resp_valid=0; busy=0; resp_hi/resp_lo=0; all internal registers cleared.
- Accept rule: a request is accepted when req_valid & req_ready & ~flush. req_ready=1 only in IDLE. One operation in flight at a time.
- States: IDLE, MUL, DIV, DONE.
- IDLE -> MUL on accept of a multiply-class op. IDLE -> DIV on accept of OP_DIV/OP_DIVU. Any other op accepted in IDLE: ignored, state stays IDLE.
- Multiply:
  - Signed ops sign-extend both operands to 2*WIDTH; unsigned ops zero-extend.
  - MADD/MADDU: result = req_hilo + product. MSUB/MSUBU: result = req_hilo - product. Both modulo 2^(2*WIDTH), no overflow trap.
  - The product passes through MUL_LAT-1 internal register stages, then goes to DONE. resp_valid rises exactly MUL_LAT cycles after the accept edge.
- Divide:
  - Restoring division on operand magnitudes.
  - Iteration count = WIDTH/DIV_BITS_PER_CYCLE; a down-counter runs in DIV.
  - Leaving DIV: signed fixup applied. Quotient is negated if a[msb]^b[msb]; remainder takes the sign of a.
  - Then DONE. resp_valid rises WIDTH/DIV_BITS_PER_CYCLE+1 cycles after accept.
- Divide by zero (deterministic): lo = all ones; hi = req_a; takes the full iteration count unless the optional feature is enabled.
- Signed MIN / -1: lo = MIN, hi = 0; no exception.
- DONE: resp_valid=1, resp_hi/resp_lo held stable until resp_ready. On resp_valid & resp_ready -> IDLE, and req_ready=1 on the following cycle (no same-cycle re-accept).
- flush:
  - Any state -> IDLE at the next edge; resp_valid=0 from that edge; the result is never delivered.
  - flush in the same cycle as resp_ready in DONE: flush wins; the result is not counted as consumed.
  - flush in the same cycle as req_valid in IDLE: the request is not accepted.
- resp_hi/resp_lo keep their last value when resp_valid=0; only the DONE-state value is defined for use.

Optional Feature:
- Macro: MULDIV_DIV_EARLY_OUT_EN.
- Defined: in the first DIV cycle, if b==0, or |a| < |b| (unsigned compare of magnitudes), go straight to DONE. Results: b==0 gives the divide-by-zero result; |a|<|b| gives lo=0, hi=a. resp_valid is then 2 cycles after accept.
- Undefined: every divide takes the full latency; results are identical either way.

Decomposition:
- Shared package (cpu_defs):
  - OP_MULT..OP_MSUBU, OP_DIV, OP_DIVU members of oper_t.
  - muldiv_state_t enum {IDLE, MUL, DIV, DONE}.
  - typedef of the 2*WIDTH hilo word.
- One sub-module: div_iter, the restoring-divide datapath (magnitudes, partial remainder, counter, sign fixup) with start/done.
- Multiply path and FSM live in muldiv_unit.

Test Plan:
- OP_MULT a=0xFFFFFFFE, b=3 -> after 3 cycles resp_hi=0xFFFFFFFF, resp_lo=0xFFFFFFFA; OP_MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- OP_MADD hilo=0x00000000_00000010, a=-2, b=4 -> hi=0, lo=0x8; OP_MSUBU hilo=0, a=1, b=1 -> hi=lo=0xFFFFFFFF.
- OP_DIV a=-7, b=2 -> resp_valid 33 cycles after accept; lo=0xFFFFFFFD, hi=0xFFFFFFFF. OP_DIVU a=7, b=2 -> lo=3, hi=1.
- Boundaries:
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU b=0 -> lo=0xFFFFFFFF, hi=a.
  - With MULDIV_DIV_EARLY_OUT_EN: DIVU a=3, b=5 -> resp_valid 2 cycles after accept, lo=0, hi=3.
- Handshake: hold resp_ready=0 for 5 cycles in DONE -> outputs stable, req_ready=0; assert resp_ready -> req_ready=1 the next cycle.
- Flush mid-DIV (cycle 10) -> resp_valid never rises, IDLE next cycle. Assert rst during MUL -> all outputs at reset values immediately.
